// File: rtl/pwm_duty_meter_if.sv
// -----------------------------------------------------------------------------
// pwm_duty_meter_if
//   Signal bundle between the 4-bit PWM generator stage and the duty meter.
//
//   Generator -> meter : pwm_in, tick_3125k (step clock), frame_195k (frame clock)
//   Meter -> observer  : duty_meas[4:0], meas_valid, frame_err, lost, duty_changed
//
//   modport master : the generator / observer side (drives sources, reads results)
//   modport slave  : the meter side
// -----------------------------------------------------------------------------
interface pwm_duty_meter_if;
  logic       pwm_in;
  logic       tick_3125k;
  logic       frame_195k;
  logic [4:0] duty_meas;
  logic       meas_valid;
  logic       frame_err;
  logic       lost;
  logic       duty_changed;

  modport master (
    output pwm_in, tick_3125k, frame_195k,
    input  duty_meas, meas_valid, frame_err, lost, duty_changed
  );

  modport slave (
    input  pwm_in, tick_3125k, frame_195k,
    output duty_meas, meas_valid, frame_err, lost, duty_changed
  );
endinterface

// File: rtl/pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// pwm_duty_meter
//   Measures the duty cycle of the 4-bit PWM generator output. Once per frame
//   (rising edge of the frame clock) it publishes how many of the step ticks
//   saw the PWM high, flags frames with the wrong tick count, and reports a
//   frame clock that has stopped while step ticks continue.
//
// Ports
//   clk_50M        in   system clock, 50 MHz
//   rst_n          in   asynchronous active-low reset
//   bus (slave)    pwm_in, tick_3125k, frame_195k      : asynchronous sources
//                  duty_meas[4:0]                      : last valid measurement
//                  meas_valid / frame_err / duty_changed: one-cycle pulses
//                  lost                                : frame clock stopped (level)
//
// Parameters
//   TICKS_PER_FRAME  step ticks expected per frame (16)
//   SYNC_STAGES      synchronizer depth per input, minimum 2
//   LOST_LIMIT       unanswered ticks before the frame clock is declared lost
//
// Build option
//   PWM_METER_CHANGE_DET_EN : when defined, duty_changed pulses with meas_valid
//   whenever the newly published value differs from the previous one; when
//   undefined no comparison register exists and duty_changed is tied to 0.
//
// Latency: pulses appear on the (SYNC_STAGES+2)th clk_50M edge after the frame
// clock rises: SYNC_STAGES edges of synchronization, one edge to register the
// detected event, one edge for the state machine to act on it.
// -----------------------------------------------------------------------------
module pwm_duty_meter #(
  parameter int TICKS_PER_FRAME = 16,
  parameter int SYNC_STAGES     = 2,
  parameter int LOST_LIMIT      = 31
) (
  input  logic             clk_50M,
  input  logic             rst_n,
  pwm_duty_meter_if.slave  bus
);

  localparam logic [4:0] TPF     = 5'(TICKS_PER_FRAME);
  localparam logic [4:0] LIM     = 5'(LOST_LIMIT);
  localparam logic [4:0] CNT_MAX = 5'd31;

  typedef enum logic [1:0] {
    IDLE,
    MEASURE,
    LOST
  } state_t;

  // ---------------------------------------------------------------------------
  // Input conditioning: synchronizer chain plus one history flop per input
  // ---------------------------------------------------------------------------
  logic [SYNC_STAGES-1:0] pwm_sync, tick_sync, frame_sync;
  logic                   pwm_hist, tick_hist, frame_hist;

  // Falling tick edge samples the PWM mid-step, away from generator transitions.
  logic tick_fall, frame_rise;
  assign tick_fall  = tick_hist & ~tick_sync[SYNC_STAGES-1];
  assign frame_rise = ~frame_hist & frame_sync[SYNC_STAGES-1];

  // Registered events and the PWM sample aligned with them.
  logic tick_ev, frame_ev, pwm_smp;

  // NOTE: the synchronizer flops carry a reset so a source that is already
  // high when reset releases still produces a clean, detectable edge.
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      pwm_sync   <= '0;
      tick_sync  <= '0;
      frame_sync <= '0;
      pwm_hist   <= 1'b0;
      tick_hist  <= 1'b0;
      frame_hist <= 1'b0;
      tick_ev    <= 1'b0;
      frame_ev   <= 1'b0;
      pwm_smp    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value of its neighbour, which is what turns this into a shift chain.
      pwm_sync   <= {pwm_sync[SYNC_STAGES-2:0],   bus.pwm_in};
      tick_sync  <= {tick_sync[SYNC_STAGES-2:0],  bus.tick_3125k};
      frame_sync <= {frame_sync[SYNC_STAGES-2:0], bus.frame_195k};
      pwm_hist   <= pwm_sync[SYNC_STAGES-1];
      tick_hist  <= tick_sync[SYNC_STAGES-1];
      frame_hist <= frame_sync[SYNC_STAGES-1];
      tick_ev    <= tick_fall;
      frame_ev   <= frame_rise;
      pwm_smp    <= pwm_hist;
    end
  end

  // ---------------------------------------------------------------------------
  // Measurement state machine
  // ---------------------------------------------------------------------------
  state_t     state, state_nxt;
  logic [4:0] tick_cnt, tick_cnt_nxt;
  logic [4:0] high_cnt, high_cnt_nxt;
  logic [4:0] duty_q, duty_nxt;
  logic       valid_q, valid_nxt;
  logic       err_q, err_nxt;
  logic       lost_q, lost_nxt;
  logic       count_en;
`ifdef PWM_METER_CHANGE_DET_EN
  logic       changed_q, changed_nxt;
`endif

  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_nxt    = state;
    tick_cnt_nxt = tick_cnt;
    high_cnt_nxt = high_cnt;
    duty_nxt     = duty_q;
    valid_nxt    = 1'b0;
    err_nxt      = 1'b0;
    lost_nxt     = lost_q;
    count_en     = 1'b0;
`ifdef PWM_METER_CHANGE_DET_EN
    changed_nxt  = 1'b0;
`endif

    // A frame event is handled first; a coincident tick then counts into
    // the freshly cleared frame via count_en below.
    unique case (state)
      IDLE: begin
        if (frame_ev) begin
          state_nxt    = MEASURE;
          tick_cnt_nxt = '0;
          high_cnt_nxt = '0;
          count_en     = tick_ev;
        end
      end

      MEASURE: begin
        if (frame_ev) begin
          if (tick_cnt == TPF) begin
            duty_nxt  = high_cnt;
            valid_nxt = 1'b1;
`ifdef PWM_METER_CHANGE_DET_EN
            // duty_q is the previously published value (0 after reset).
            changed_nxt = (high_cnt != duty_q);
`endif
          end else begin
            err_nxt = 1'b1;
          end
          tick_cnt_nxt = '0;
          high_cnt_nxt = '0;
        end
        count_en = tick_ev;
      end

      LOST: begin
        if (frame_ev) begin
          state_nxt    = MEASURE;
          lost_nxt     = 1'b0;
          tick_cnt_nxt = '0;
          high_cnt_nxt = '0;
          count_en     = tick_ev;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    // Both counters saturate; reaching the tick limit means the frame clock
    // has gone quiet, so the lost flag rises on the same edge.
    if (count_en) begin
      tick_cnt_nxt = (tick_cnt_nxt >= LIM) ? LIM : tick_cnt_nxt + 5'd1;
      high_cnt_nxt = (high_cnt_nxt == CNT_MAX) ? CNT_MAX
                                               : high_cnt_nxt + {4'b0, pwm_smp};
      if (tick_cnt_nxt == LIM) begin
        state_nxt = LOST;
        lost_nxt  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      tick_cnt <= '0;
      high_cnt <= '0;
      duty_q   <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      lost_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      tick_cnt <= tick_cnt_nxt;
      high_cnt <= high_cnt_nxt;
      duty_q   <= duty_nxt;
      valid_q  <= valid_nxt;
      err_q    <= err_nxt;
      lost_q   <= lost_nxt;
    end
  end

`ifdef PWM_METER_CHANGE_DET_EN
  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      changed_q <= 1'b0;
    end else begin
      changed_q <= changed_nxt;
    end
  end
  assign bus.duty_changed = changed_q;
`else
  assign bus.duty_changed = 1'b0;
`endif

  assign bus.duty_meas  = duty_q;
  assign bus.meas_valid = valid_q;
  assign bus.frame_err  = err_q;
  assign bus.lost       = lost_q;

endmodule

// File: tb/tb_pwm_duty_meter.sv
// -----------------------------------------------------------------------------
// tb_pwm_duty_meter
//   Drives synthetic generator sources (step tick = 16 clk_50M cycles, 8 high /
//   8 low; frame = 16 ticks unless a row says otherwise; PWM high for the first
//   N steps). Each frame row carries the hand-computed result expected at the
//   frame edge that starts it, which reports the previous frame. Expected
//   pulses go into a scoreboard queue; an independent monitor pops and
//   compares whenever the DUT shows a pulse.
// -----------------------------------------------------------------------------
module tb_pwm_duty_meter;

`ifdef PWM_METER_CHANGE_DET_EN
  localparam bit CD = 1'b1;
`else
  localparam bit CD = 1'b0;
`endif
  localparam int LATENCY = 4;  // SYNC_STAGES + 2 with default parameters

  typedef enum int {K_NONE, K_VALID, K_ERR} kind_t;

  typedef struct {
    logic       valid;
    logic       err;
    logic [4:0] duty;
    logic       changed;
    int         cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb[$];

  pwm_duty_meter_if bus ();

  pwm_duty_meter dut (
    .clk_50M (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse cycle must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && (bus.meas_valid || bus.frame_err || bus.duty_changed)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse",
              {29'd0, bus.meas_valid, bus.frame_err, bus.duty_changed}, 0);
      end else begin
        e = sb.pop_front();
        check("meas_valid",   bus.meas_valid,   e.valid);
        check("frame_err",    bus.frame_err,    e.err);
        check("duty_meas",    bus.duty_meas,    e.duty);
        check("duty_changed", bus.duty_changed, e.changed);
        check("pulse_cycle",  cyc,              e.cyc);
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One frame: n high steps out of 'ticks'. 'edge_en' raises the frame clock
  // at step 0; 'kind/duty/ch' describe what that edge must report.
  // lost is checked at the end of each step: expected high once 'lost_at'
  // ticks have gone unanswered (0 = never).
  task automatic run_frame(input int n, input int ticks, input bit edge_en,
                           input kind_t kind, input int duty, input bit ch,
                           input int lost_at);
    exp_t e;
    for (int s = 0; s < ticks; s++) begin
      bus.tick_3125k = 1'b1;
      bus.pwm_in     = (s < n);
      if (s == 0 && edge_en) begin
        bus.frame_195k = 1'b1;
        if (kind != K_NONE) begin
          e.valid   = (kind == K_VALID);
          e.err     = (kind == K_ERR);
          e.duty    = 5'(duty);
          e.changed = ch & CD;
          e.cyc     = cyc + LATENCY;
          sb.push_back(e);
        end
      end
      if (s == 4) bus.frame_195k = 1'b0;
      wait_cycles(8);
      bus.tick_3125k = 1'b0;
      wait_cycles(8);
      check("lost", bus.lost, (lost_at != 0 && s + 1 >= lost_at) ? 1 : 0);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_duty_meas"},    bus.duty_meas,    0);
    check({tag, "_meas_valid"},   bus.meas_valid,   0);
    check({tag, "_frame_err"},    bus.frame_err,    0);
    check({tag, "_lost"},         bus.lost,         0);
    check({tag, "_duty_changed"}, bus.duty_changed, 0);
  endtask

  initial begin
    rst_n          = 1'b0;
    bus.pwm_in     = 1'b0;
    bus.tick_3125k = 1'b0;
    bus.frame_195k = 1'b0;
    #5;
    check_all_zero("reset");
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);

    // IDLE ignores ticks: 40 ticks without a frame edge must not set lost.
    run_frame(3, 40, 1'b0, K_NONE, 0, 1'b0, 0);

    // N=0 for three frames; first edge only leaves IDLE.
    run_frame(0, 16, 1'b1, K_NONE,   0, 1'b0, 0);
    run_frame(0, 16, 1'b1, K_VALID,  0, 1'b0, 0);
    run_frame(0, 16, 1'b1, K_VALID,  0, 1'b0, 0);
    // N=5, 5, 11, then held high, then held low.
    run_frame(5, 16, 1'b1, K_VALID,  0, 1'b0, 0);
    run_frame(5, 16, 1'b1, K_VALID,  5, 1'b1, 0);
    run_frame(11, 16, 1'b1, K_VALID, 5, 1'b0, 0);
    run_frame(16, 16, 1'b1, K_VALID, 11, 1'b1, 0);
    run_frame(0, 16, 1'b1, K_VALID,  16, 1'b1, 0);
    // Short frame (15 ticks, N=7): error, duty_meas holds 0; next reports 7.
    run_frame(7, 15, 1'b1, K_VALID,  0, 1'b1, 0);
    run_frame(7, 16, 1'b1, K_ERR,    0, 1'b0, 0);
    run_frame(3, 16, 1'b1, K_VALID,  7, 1'b1, 0);
    // Frame clock stops after this edge: lost from the 31st tick onward.
    run_frame(3, 40, 1'b1, K_VALID,  3, 1'b1, 31);
    // Restart: first frame unreported, second reports its N.
    run_frame(4, 16, 1'b1, K_NONE,   0, 1'b0, 0);
    run_frame(9, 16, 1'b1, K_VALID,  4, 1'b1, 0);
    // Reset mid-frame (N=9): outputs clear at once, partial frame discarded.
    run_frame(9, 8, 1'b1, K_VALID,   9, 1'b1, 0);
    rst_n = 1'b0;
    #2;
    check_all_zero("mid_reset");
    wait_cycles(3);
    rst_n = 1'b1;
    wait_cycles(2);
    run_frame(9, 16, 1'b1, K_NONE,   0, 1'b0, 0);
    run_frame(9, 16, 1'b1, K_VALID,  9, 1'b1, 0);
    run_frame(0, 16, 1'b1, K_VALID,  9, 1'b0, 0);

    wait_cycles(20);
    check("scoreboard_left", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
